// File: rtl/axi_lite_mem_arbiter_pkg.sv
// Shared types and constants for the two-master AXI4-Lite memory arbiter.
// Holds the FSM state encoding and the AXI response codes.
package AxiArbPkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } ArbState;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_lite_mem_arbiter_rr_arb2.sv
// Two-input round-robin picker.
// The "last" pointer remembers the previous winner so that a tie goes to the other master.
module rr_arb2 (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic [1:0] gnt
);

  logic last;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Starts at 1 so master 0 wins the first tie after reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      last <= 1'b1;
    end else if (grant_en && (req != 2'b00)) begin
      last <= gnt[1];
    end
  end

endmodule

// File: rtl/axi_lite_mem_arbiter.sv
// Serialises the IF (master 0) and MEM (master 1) AXI4-Lite ports onto one RAM slave.
// One transaction in flight at a time; the owner gets pass-through, the other master sees zeros.
module axi_lite_mem_arbiter
  import AxiArbPkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] s0_awaddr,
  input  logic              s0_awvalid,
  output logic              s0_awready,
  input  logic [DATA_W-1:0] s0_wdata,
  input  logic [DATA_W/8-1:0] s0_wstrb,
  input  logic              s0_wvalid,
  output logic              s0_wready,
  output logic [1:0]        s0_bresp,
  output logic              s0_bvalid,
  input  logic              s0_bready,
  input  logic [ADDR_W-1:0] s0_araddr,
  input  logic              s0_arvalid,
  output logic              s0_arready,
  output logic [DATA_W-1:0] s0_rdata,
  output logic [1:0]        s0_rresp,
  output logic              s0_rvalid,
  input  logic              s0_rready,
  input  logic [ADDR_W-1:0] s1_awaddr,
  input  logic              s1_awvalid,
  output logic              s1_awready,
  input  logic [DATA_W-1:0] s1_wdata,
  input  logic [DATA_W/8-1:0] s1_wstrb,
  input  logic              s1_wvalid,
  output logic              s1_wready,
  output logic [1:0]        s1_bresp,
  output logic              s1_bvalid,
  input  logic              s1_bready,
  input  logic [ADDR_W-1:0] s1_araddr,
  input  logic              s1_arvalid,
  output logic              s1_arready,
  output logic [DATA_W-1:0] s1_rdata,
  output logic [1:0]        s1_rresp,
  output logic              s1_rvalid,
  input  logic              s1_rready,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [DATA_W-1:0] m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic              m_wvalid,
  input  logic              m_wready,
  input  logic [1:0]        m_bresp,
  input  logic              m_bvalid,
  output logic              m_bready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic [1:0]        grant
);

  localparam int STRB_W = DATA_W / 8;

  ArbState state, state_n;
  logic own, aw_done, w_done, ar_done;
  logic [1:0] req, gnt;
  logic grant_en;

  logic [ADDR_W-1:0] o_awaddr, o_araddr;
  logic [DATA_W-1:0] o_wdata;
  logic [STRB_W-1:0] o_wstrb;
  logic o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready;
  logic aw_rdy, w_rdy, ar_rdy, b_fwd, r_fwd;

  assign req = {s1_awvalid | s1_arvalid, s0_awvalid | s0_arvalid};

  rr_arb2 u_rr (
    .clk      (clk),
    .rstn     (rstn),
    .req      (req),
    .grant_en (grant_en),
    .gnt      (gnt)
  );

  assign o_awaddr  = own ? s1_awaddr  : s0_awaddr;
  assign o_awvalid = own ? s1_awvalid : s0_awvalid;
  assign o_wdata   = own ? s1_wdata   : s0_wdata;
  assign o_wstrb   = own ? s1_wstrb   : s0_wstrb;
  assign o_wvalid  = own ? s1_wvalid  : s0_wvalid;
  assign o_bready  = own ? s1_bready  : s0_bready;
  assign o_araddr  = own ? s1_araddr  : s0_araddr;
  assign o_arvalid = own ? s1_arvalid : s0_arvalid;
  assign o_rready  = own ? s1_rready  : s0_rready;

  // Downstream side: only the owner's channels pass through, each gated by its done flag.
  always_comb begin
    m_awaddr  = '0;
    m_awvalid = 1'b0;
    m_wdata   = '0;
    m_wstrb   = '0;
    m_wvalid  = 1'b0;
    m_bready  = 1'b0;
    m_araddr  = '0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    aw_rdy    = 1'b0;
    w_rdy     = 1'b0;
    ar_rdy    = 1'b0;
    b_fwd     = 1'b0;
    r_fwd     = 1'b0;
    case (state)
      RD: begin
        m_araddr  = o_araddr;
        m_arvalid = o_arvalid & ~ar_done;
        ar_rdy    = m_arready & ~ar_done;
        r_fwd     = ar_done;
        m_rready  = ar_done & o_rready;
      end
      WR: begin
        m_awaddr  = o_awaddr;
        m_awvalid = o_awvalid & ~aw_done;
        aw_rdy    = m_awready & ~aw_done;
        m_wdata   = o_wdata;
        m_wstrb   = o_wstrb;
        m_wvalid  = o_wvalid & ~w_done;
        w_rdy     = m_wready & ~w_done;
        b_fwd     = aw_done & w_done;
        m_bready  = aw_done & w_done & o_bready;
      end
      default: ;
    endcase
  end

  // Upstream side: demux towards the owner, zeros towards the other master.
  always_comb begin
    s0_awready = ~own & aw_rdy;
    s1_awready =  own & aw_rdy;
    s0_wready  = ~own & w_rdy;
    s1_wready  =  own & w_rdy;
    s0_arready = ~own & ar_rdy;
    s1_arready =  own & ar_rdy;
    s0_bvalid  = ~own & b_fwd & m_bvalid;
    s1_bvalid  =  own & b_fwd & m_bvalid;
    s0_bresp   = (~own & b_fwd) ? m_bresp : RESP_OKAY;
    s1_bresp   = ( own & b_fwd) ? m_bresp : RESP_OKAY;
    s0_rvalid  = ~own & r_fwd & m_rvalid;
    s1_rvalid  =  own & r_fwd & m_rvalid;
    s0_rresp   = (~own & r_fwd) ? m_rresp : RESP_OKAY;
    s1_rresp   = ( own & r_fwd) ? m_rresp : RESP_OKAY;
    s0_rdata   = (~own & r_fwd) ? m_rdata : '0;
    s1_rdata   = ( own & r_fwd) ? m_rdata : '0;
  end

  assign grant = (state == IDLE) ? 2'b00 : {own, ~own};

  always_comb begin
    state_n  = state;
    grant_en = 1'b0;
    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          grant_en = 1'b1;
          state_n  = (gnt[1] ? s1_awvalid : s0_awvalid) ? WR : RD;
        end
      end
      RD: if (m_rvalid && m_rready) state_n = IDLE;
      WR: if (m_bvalid && m_bready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      own     <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      ar_done <= 1'b0;
    end else begin
      state <= state_n;
      if (grant_en) own <= gnt[1];
      // Flags are only ever set inside their own state and cleared by that state's response.
      if (state == RD) begin
        if (m_rvalid && m_rready)        ar_done <= 1'b0;
        else if (m_arvalid && m_arready) ar_done <= 1'b1;
      end
      if (state == WR) begin
        if (m_bvalid && m_bready) begin
          aw_done <= 1'b0;
          w_done  <= 1'b0;
        end else begin
          if (m_awvalid && m_awready) aw_done <= 1'b1;
          if (m_wvalid && m_wready)   w_done  <= 1'b1;
        end
      end
    end
  end

endmodule
